eq_gain_regbank: RTL
====================

# eq_gain_regbank

Parametrised, double-buffered successor to the equaliser register map. Holds a configuration byte and NUM_BANDS gain words of GAIN_WIDTH bits, written byte-wise little-endian into a shadow bank. The shadow bank is copied atomically to the active outputs only at an audio sample boundary, after an explicit commit command. It sits between the host byte interface and the per-band gain multipliers, and adds byte readback so the host can verify what it wrote.

## Interface
- NUM_BANDS, 10, number of gain words (1..32)
- GAIN_WIDTH, 24, bits per gain word (1..32)
- ADDR_WIDTH, 8, byte-address width; must cover CMD_ADDR
- GAIN_RESET, 0, reset value of every shadow and active gain word
- Derived constants:
  - BPG = ceil(GAIN_WIDTH/8), bytes per gain.
  - CMD_ADDR = NUM_BANDS*BPG + 1, which is 31 at the defaults.

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- we  in  1  write strobe, sampled at posedge
- re  in  1  read strobe, sampled at posedge
- addr  in  ADDR_WIDTH  byte address
- data_in  in  8  write data
- rdata  out  8  read data, registered
- rvalid  out  1  one-cycle pulse, rdata valid
- sample_tick  in  1  one-cycle pulse per audio sample
- configuration  out  8  active configuration byte
- gains  out  NUM_BANDS*GAIN_WIDTH  active gains, band k (1-based) at bits [k*GAIN_WIDTH-1 : (k-1)*GAIN_WIDTH]
- commit_pending  out  1  commit requested, not yet applied
- commit_done  out  1  one-cycle pulse after active bank update
- addr_err  out  1  one-cycle pulse on access to an unmapped address

## Operation
- Address map:
  - 0: configuration.
  - 1 + (k-1)*BPG + j: byte j (0 = LSB) of gain k.
  - CMD_ADDR: command/status register.
  - All other addresses are unmapped.
- Gain bytes whose bit range exceeds GAIN_WIDTH:
  - Excess bits are discarded on write.
  - Excess bits read back as 0.
- Writes (we=1, mapped address) update the shadow bank only. Active outputs do not change on a write.
- Commands (write to CMD_ADDR):
  - data_in[0]=1 sets pending.
  - data_in[1]=1 clears pending (cancel). Cancel wins if both bits are set.
  - Other bits are ignored.
- Reads:
  - Address 0 and gain addresses return the shadow value.
  - CMD_ADDR returns {7'b0, commit_pending}.
  - Unmapped addresses return 0x00.
- Commit state machine, states IDLE and PENDING:
  - IDLE -> PENDING on a commit command.
  - PENDING -> IDLE on a cancel command. No update, no commit_done.
  - PENDING with sample_tick=1 at an edge: all of the following happen at that edge.
    - Every active register (configuration + all gains) loads the shadow value as it stood before that edge.
    - The state returns to IDLE.
    - commit_done is driven high for exactly the following cycle.
  - A commit command while already PENDING has no further effect.
- Unmapped access: we=1 or re=1 to an unmapped address pulses addr_err. Such a write has no effect; such a read returns rdata=0x00 with rvalid.

## Timing
- Reset: all of the following are asynchronous on rst low.
  - Shadow and active configuration = 0x00.
  - All shadow and active gains = GAIN_RESET.
  - rdata = 0x00.
  - rvalid, commit_pending, commit_done, addr_err = 0.
  - State = IDLE.
- Reset asserted while PENDING aborts the commit. No commit_done is produced.
- Write latency: the shadow value is visible to a read issued at the next edge.
- Read latency: rdata and rvalid are valid the cycle after the edge that sampled re=1. rdata holds its value until the next read.
- we and re to the same address at the same edge: rdata returns the pre-write value.
- Gain write at the same edge as the commit transfer: the active bank gets the old shadow byte and the shadow gets the new byte. The new byte waits for the next commit.
- Commit command and sample_tick at the same edge: pending is set, but the transfer waits for the next sample_tick. Minimum command-to-update latency is therefore one tick.
- Cancel and sample_tick at the same edge while PENDING: the transfer happens. Cancel has no effect once the transfer has fired.
- commit_pending reflects state == PENDING. It falls the cycle commit_done rises.
- Active outputs are glitch-free registers. All bits of all bands change on the same edge.

## Test plan
- Reset check: rst low mid-run -> configuration=0x00, every gain=GAIN_RESET, all status outputs 0, read of CMD_ADDR returns 0x00.
- Shadow write and readback:
  - Stimulus: write gain 2 bytes 0xC7, 0x71, 0x1C to addresses 4..6, then read addresses 4..6.
  - Required: reads return 0xC7, 0x71, 0x1C with a one-cycle rvalid each; gain_2 output is still 0.
- Default-map commit:
  - Stimulus: full default map written (configuration 0xAA, band 10 = 0xFFFFFF), write 0x01 to address 31, pulse sample_tick 5 cycles later.
  - Required: commit_pending is 1 until the tick edge; every band updates on that same edge; commit_done pulses once; read of address 31 returns 0x00 afterwards.
- Cancel:
  - Stimulus: commit 0x01, then 0x03 to address 31, then sample_tick.
  - Required: outputs unchanged, no commit_done, pending 0.
- Collision:
  - Stimulus: with PENDING active, write 0x55 to address 1 at the same edge as sample_tick.
  - Required: active gain_1 LSB keeps its old shadow value; a second commit then loads 0x55.
- Parameter sweep:
  - Stimulus: NUM_BANDS=4, GAIN_WIDTH=12 (BPG=2, CMD_ADDR=9). Write 0xFF to addresses 1 and 2. Access address 10.
  - Required: gain_1 becomes 0xFFF after commit; reading address 2 returns 0x0F; the access to address 10 pulses addr_err and returns rdata=0x00.

Source files
------------

// File: rtl/eq_gain_regbank.sv
// Double-buffered equaliser gain register bank: byte-wise host writes land in a
// shadow bank that is copied to the active outputs on a sample tick after a commit.
module eq_gain_regbank #(
    parameter int                    NUM_BANDS  = 10,
    parameter int                    GAIN_WIDTH = 24,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [GAIN_WIDTH-1:0] GAIN_RESET = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic                            re,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [7:0]                      data_in,
    output logic [7:0]                      rdata,
    output logic                            rvalid,
    input  logic                            sample_tick,
    output logic [7:0]                      configuration,
    output logic [NUM_BANDS*GAIN_WIDTH-1:0] gains,
    output logic                            commit_pending,
    output logic                            commit_done,
    output logic                            addr_err
);

    localparam int BPG      = (GAIN_WIDTH + 7) / 8;
    localparam int PADW     = BPG * 8;
    localparam int CMD_ADDR = NUM_BANDS * BPG + 1;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t                                 state_q, state_d;
    logic [7:0]                             cfg_sh_q, cfg_sh_d;
    logic [7:0]                             cfg_act_q, cfg_act_d;
    logic [NUM_BANDS-1:0][GAIN_WIDTH-1:0]   gain_sh_q, gain_sh_d;
    logic [NUM_BANDS-1:0][GAIN_WIDTH-1:0]   gain_act_q, gain_act_d;
    logic [7:0]                             rdata_q, rdata_d;
    logic                                   rvalid_q, rvalid_d;
    logic                                   done_q, done_d;
    logic                                   err_q, err_d;

    logic [31:0]                            addr_w;
    logic                                   hit_cfg, hit_cmd, hit_gain, unmapped;
    logic [NUM_BANDS-1:0][BPG-1:0]          gsel;
    logic [NUM_BANDS-1:0][PADW-1:0]         gain_sh_pad;
    logic                                   cmd_wr, xfer;

    assign addr_w = 32'(addr);

    // Address decode: one-hot select over every gain byte slot.
    always_comb begin
        gsel = '0;
        for (int k = 0; k < NUM_BANDS; k++) begin
            for (int j = 0; j < BPG; j++) begin
                if (addr_w == 32'(1 + k * BPG + j)) gsel[k][j] = 1'b1;
            end
        end
    end

    assign hit_cfg  = (addr_w == 32'd0);
    assign hit_cmd  = (addr_w == 32'(CMD_ADDR));
    assign hit_gain = |gsel;
    assign unmapped = !(hit_cfg || hit_cmd || hit_gain);
    assign cmd_wr   = we && hit_cmd;

    // Zero-padded view so excess bits of the top byte read back as 0.
    always_comb begin
        for (int k = 0; k < NUM_BANDS; k++) begin
            gain_sh_pad[k] = PADW'(gain_sh_q[k]);
        end
    end

    // Shadow bank writes; bits beyond GAIN_WIDTH are dropped by the truncation.
    always_comb begin
        logic [PADW-1:0] pad;
        pad       = '0;
        cfg_sh_d  = cfg_sh_q;
        gain_sh_d = gain_sh_q;
        if (we) begin
            if (hit_cfg) cfg_sh_d = data_in;
            for (int k = 0; k < NUM_BANDS; k++) begin
                for (int j = 0; j < BPG; j++) begin
                    if (gsel[k][j]) begin
                        pad              = gain_sh_pad[k];
                        pad[8*j +: 8]    = data_in;
                        gain_sh_d[k]     = GAIN_WIDTH'(pad);
                    end
                end
            end
        end
    end

    // Reads see the pre-edge shadow, so a same-edge write is not visible yet.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (re) begin
            rvalid_d = 1'b1;
            rdata_d  = 8'h00;
            if (hit_cfg) rdata_d = cfg_sh_q;
            if (hit_cmd) rdata_d = {7'b0, state_q == PENDING};
            for (int k = 0; k < NUM_BANDS; k++) begin
                for (int j = 0; j < BPG; j++) begin
                    if (gsel[k][j]) rdata_d = gain_sh_pad[k][8*j +: 8];
                end
            end
        end
    end

    assign err_d = (we || re) && unmapped;

    // Commit FSM: a pending tick beats a same-edge cancel.
    always_comb begin
        state_d = state_q;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_wr && data_in[0] && !data_in[1]) state_d = PENDING;
            end
            PENDING: begin
                if (sample_tick) begin
                    xfer    = 1'b1;
                    state_d = IDLE;
                end else if (cmd_wr && data_in[1]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_d     = xfer;
    assign cfg_act_d  = xfer ? cfg_sh_q  : cfg_act_q;
    assign gain_act_d = xfer ? gain_sh_q : gain_act_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cfg_sh_q   <= 8'h00;
            cfg_act_q  <= 8'h00;
            gain_sh_q  <= {NUM_BANDS{GAIN_RESET}};
            gain_act_q <= {NUM_BANDS{GAIN_RESET}};
            rdata_q    <= 8'h00;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_sh_q   <= cfg_sh_d;
            cfg_act_q  <= cfg_act_d;
            gain_sh_q  <= gain_sh_d;
            gain_act_q <= gain_act_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rdata          = rdata_q;
    assign rvalid         = rvalid_q;
    assign configuration  = cfg_act_q;
    assign gains          = gain_act_q;
    assign commit_pending = (state_q == PENDING);
    assign commit_done    = done_q;
    assign addr_err       = err_q;

endmodule
